// File: rtl/pred_pkg.sv
// Shared types and constants for the branch outcome driver and its predictor peer.
package pred_pkg;

    typedef enum logic [2:0] {
        PRIME = 3'd0,
        IDLE  = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        RES   = 3'd4
    } drv_state_e;

    localparam int CNT_W_DEF = 16;

    // 2-bit saturating predictor encoding; the MSB is the predicted direction.
    localparam logic [1:0] PRED_SNT = 2'd0;
    localparam logic [1:0] PRED_WNT = 2'd1;
    localparam logic [1:0] PRED_WT  = 2'd2;
    localparam logic [1:0] PRED_ST  = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_outcome_driver.sv
// Runs one predict-then-resolve handshake per accepted branch outcome and keeps
// saturating totals of branches, correct predictions and mispredictions.
//
// state | meaning
// PRIME | one result pulse with taken=0 to arm the predictor after reset
// IDLE  | ready for the next outcome
// REQ   | request pulse to the predictor
// WAIT  | prediction is stable; captured at the closing edge
// RES   | result pulse with the actual direction; statistics update
module branch_outcome_driver
    import pred_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             outcome_valid,
    input  logic             outcome_taken,
    output logic             outcome_ready,
    output logic             request,
    input  logic             prediction,
    output logic             result,
    output logic             taken,
    output logic             pred_valid,
    output logic             pred_out,
    output logic             mispredict,
    output logic             busy,
    output logic [CNT_W-1:0] n_total,
    output logic [CNT_W-1:0] n_correct,
    output logic [CNT_W-1:0] n_miss
);

    drv_state_e state_q, state_d;
    logic       act_q, act_d;
    logic       pred_q, pred_d;
    logic       inc_total, inc_correct, inc_miss;
    logic       miss;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= PRIME;
            act_q   <= 1'b0;
            pred_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            pred_q  <= pred_d;
        end
    end

    assign miss = pred_q ^ act_q;

    always_comb begin
        state_d       = state_q;
        act_d         = act_q;
        pred_d        = pred_q;
        outcome_ready = 1'b0;
        request       = 1'b0;
        result        = 1'b0;
        taken         = 1'b0;
        pred_valid    = 1'b0;
        mispredict    = 1'b0;
        inc_total     = 1'b0;
        inc_correct   = 1'b0;
        inc_miss      = 1'b0;
        case (state_q)
            PRIME: begin
                // Gated so the arming pulse stays one cycle however long reset is held.
                result  = rst_n;
                state_d = IDLE;
            end
            IDLE: begin
                outcome_ready = 1'b1;
                if (outcome_valid) begin
                    act_d   = outcome_taken;
                    state_d = REQ;
                end
            end
            REQ: begin
                request = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                pred_d  = prediction;
                state_d = RES;
            end
            RES: begin
                result      = 1'b1;
                taken       = act_q;
                pred_valid  = 1'b1;
                mispredict  = miss;
                inc_total   = 1'b1;
                inc_correct = ~miss;
                inc_miss    = miss;
                state_d     = IDLE;
            end
            default: begin
                state_d = PRIME;
            end
        endcase
    end

    assign pred_out = pred_q;
    assign busy     = (state_q != IDLE);

    sat_counter #(.CNT_W(CNT_W)) u_cnt_total (
        .clk   (clk),
        .clr   (~rst_n),
        .inc   (inc_total),
        .count (n_total)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_correct (
        .clk   (clk),
        .clr   (~rst_n),
        .inc   (inc_correct),
        .count (n_correct)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_miss (
        .clk   (clk),
        .clr   (~rst_n),
        .inc   (inc_miss),
        .count (n_miss)
    );

endmodule
